// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the 8-bit ADC front end: flushes the sample FIFO, settles,
// arms a rising level-crossing trigger, then writes a fixed-length burst into the FIFO.
module adc_capture_ctrl #(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int LEN_W         = 16
) (
  input  logic             ad0_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             trig_en,
  input  logic [7:0]       trig_level,
  input  logic [LEN_W-1:0] cap_len,
  input  logic [7:0]       ad_data,
  input  logic             fifo_full,
  input  logic             ack,
  output logic             fifo_rst,
  output logic             wr_en,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SETTLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       d1_q, d2_q;
  logic [7:0]       dly_q, dly_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             frst_q, frst_d;
  logic             wen_q, wen_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             ovf_q, ovf_d;
  logic             trig_hit;
  logic             attempt;

  assign trig_hit = (d2_q < trig_level) && (d1_q >= trig_level);

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    frst_d  = 1'b0;
    wen_d   = 1'b0;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    attempt = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FLUSH;
          len_d   = (cap_len == '0) ? LEN_W'(1) : cap_len;
          cnt_d   = '0;
          dly_d   = '0;
          ovf_d   = 1'b0;
          frst_d  = 1'b1;
        end
      end
      S_FLUSH: begin
        if (dly_q == 8'(RST_CYCLES - 1)) begin
          state_d = S_SETTLE;
          dly_d   = '0;
        end else begin
          frst_d = 1'b1;
          dly_d  = dly_q + 8'd1;
        end
      end
      S_SETTLE: begin
        if (dly_q == 8'(SETTLE_CYCLES - 1)) begin
          state_d = S_ARMED;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + 8'd1;
        end
      end
      S_ARMED:   attempt = !trig_en || trig_hit;
      S_CAPTURE: attempt = 1'b1;
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A full FIFO still consumes the slot so the burst length in cycles is fixed.
    if (attempt) begin
      cnt_d   = cnt_q + LEN_W'(1);
      state_d = (cnt_q == len_q - LEN_W'(1)) ? S_DONE : S_CAPTURE;
      if (fifo_full) begin
        ovf_d = 1'b1;
      end else begin
        wen_d   = 1'b1;
        wdata_d = d1_q;
      end
    end

    if (abort) begin
      state_d = S_IDLE;
      dly_d   = dly_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      frst_d  = 1'b0;
      wen_d   = 1'b0;
      wdata_d = wdata_q;
      ovf_d   = ovf_q;
    end
  end

  always_ff @(posedge ad0_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      d1_q    <= '0;
      d2_q    <= '0;
      dly_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      frst_q  <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d1_q    <= ad_data;
      d2_q    <= d1_q;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      frst_q  <= frst_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fifo_rst = frst_q;
  assign wr_en    = wen_q;
  assign wr_data  = wdata_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: IDLE control table, directed bursts and randomized bursts
// checked against a timeline model of the capture sequence.
module tb_adc_capture_ctrl;

  localparam int RSTC = 4;
  localparam int SETC = 8;
  localparam int LW   = 16;
  localparam int EARM = RSTC + SETC + 1;

  logic          clk = 1'b0;
  logic          rst, start, abort, trig_en, fifo_full, ack;
  logic [7:0]    trig_level, ad_data;
  logic [LW-1:0] cap_len;
  logic          fifo_rst, wr_en, busy, done, overflow;
  logic [7:0]    wr_data;

  int            nvec = 0;
  int            nmis = 0;
  logic [7:0]    exp_wd = 8'd0;
  logic [7:0]    dat [64];
  logic          ful [64];

  adc_capture_ctrl #(.RST_CYCLES(RSTC), .SETTLE_CYCLES(SETC), .LEN_W(LW)) dut (
    .ad0_clk(clk), .rst(rst), .start(start), .abort(abort), .trig_en(trig_en),
    .trig_level(trig_level), .cap_len(cap_len), .ad_data(ad_data), .fifo_full(fifo_full),
    .ack(ack), .fifo_rst(fifo_rst), .wr_en(wr_en), .wr_data(wr_data), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic expv);
    nvec++;
    if (act !== expv) begin
      nmis++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] expv);
    nvec++;
    if (act !== expv) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic eb, input logic ed, input logic ef,
                           input logic ew, input logic [7:0] ewd, input logic eo);
    chk1({tag, ".busy"}, busy, eb);
    chk1({tag, ".done"}, done, ed);
    chk1({tag, ".fifo_rst"}, fifo_rst, ef);
    chk1({tag, ".wr_en"}, wr_en, ew);
    chk8({tag, ".wr_data"}, wr_data, ewd);
    chk1({tag, ".overflow"}, overflow, eo);
  endtask

  // One capture from IDLE. Expected outputs come from the edge timeline:
  // edge 0 takes start, attempts occupy edges a..a+len-1, done follows the last one.
  task automatic run_capture(input string tag, input int clen, input logic ten,
                             input logic [7:0] lvl, input int stop_in, input int kind_in,
                             input logic noise);
    int   len, n, a, stop_e, kind;
    logic ovf, att, done_now;
    len = (clen == 0) ? 1 : clen;
    n   = EARM + 20 + len;
    a   = -1;
    ovf = 1'b0;
    stop_e = (stop_in < 1 || stop_in > n) ? n : stop_in;
    for (int e = EARM; e < n; e++) begin
      if (!ten || (dat[e-2] < lvl && dat[e-1] >= lvl)) begin
        a = e;
        break;
      end
    end
    for (int e = 0; e < stop_e; e++) begin
      rst        = 1'b0;
      abort      = 1'b0;
      start      = (e == 0) || (noise && $urandom_range(0, 3) == 0);
      cap_len    = (e == 0) ? LW'(clen) : LW'($urandom);
      trig_en    = ten;
      trig_level = lvl;
      ad_data    = dat[e];
      fifo_full  = ful[e];
      ack        = noise && !(a >= 0 && e >= a + len) && ($urandom_range(0, 3) == 0);
      tick();
      att = (a >= 0) && (e >= a) && (e < a + len);
      if (att && !ful[e]) exp_wd = dat[e-1];
      if (att && ful[e]) ovf = 1'b1;
      check_all(tag, 1'b1, (a >= 0) && (e >= a + len - 1), e < RSTC, att && !ful[e], exp_wd, ovf);
    end
    done_now = (a >= 0) && (stop_e >= a + len);
    kind = kind_in;
    if (kind == 0 && !done_now) kind = 1;
    start   = noise && ($urandom_range(0, 1) == 0);
    ack     = (kind == 0) || (noise && ($urandom_range(0, 1) == 0));
    abort   = (kind == 1);
    rst     = (kind == 2);
    ad_data = dat[stop_e];
    tick();
    if (kind == 2) begin
      ovf    = 1'b0;
      exp_wd = 8'd0;
    end
    check_all({tag, ".stop"}, 1'b0, 1'b0, 1'b0, 1'b0, exp_wd, ovf);
    start = 1'b0;
    ack   = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    tick();
    check_all({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, exp_wd, ovf);
  endtask

  typedef struct {
    logic r, s, a, k;
    logic eb, ef;
  } vec_t;

  initial begin
    vec_t tbl [10];
    tbl[0] = '{r:1, s:0, a:0, k:0, eb:0, ef:0};
    tbl[1] = '{r:0, s:0, a:0, k:1, eb:0, ef:0};
    tbl[2] = '{r:0, s:1, a:1, k:0, eb:0, ef:0};
    tbl[3] = '{r:0, s:1, a:0, k:1, eb:1, ef:1};
    tbl[4] = '{r:0, s:0, a:0, k:0, eb:1, ef:1};
    tbl[5] = '{r:0, s:1, a:0, k:0, eb:1, ef:1};
    tbl[6] = '{r:0, s:0, a:1, k:0, eb:0, ef:0};
    tbl[7] = '{r:0, s:1, a:0, k:0, eb:1, ef:1};
    tbl[8] = '{r:1, s:0, a:0, k:0, eb:0, ef:0};
    tbl[9] = '{r:0, s:0, a:0, k:0, eb:0, ef:0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0; trig_en = 1'b0;
    trig_level = 8'd0; cap_len = LW'(5); ad_data = 8'd0; fifo_full = 1'b0;
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].r; start = tbl[i].s; abort = tbl[i].a; ack = tbl[i].k;
      tick();
      check_all($sformatf("tbl%0d", i), tbl[i].eb, 1'b0, tbl[i].ef, 1'b0, 8'd0, 1'b0);
    end
    start = 1'b0;

    // Plain burst of 5 with a distinct ramp so a wrong data latency shows up.
    for (int e = 0; e < 64; e++) begin dat[e] = 8'(e * 7 + 3); ful[e] = 1'b0; end
    run_capture("t1", 5, 1'b0, 8'd0, -1, 0, 1'b0);

    // Level 200 held through ARMED, then a ramp crosses 128 on the sample equal to 128.
    for (int e = 0; e < 64; e++) begin dat[e] = 8'd200; ful[e] = 1'b0; end
    dat[24] = 8'd100; dat[25] = 8'd120; dat[26] = 8'd127; dat[27] = 8'd128; dat[28] = 8'd200;
    run_capture("t2", 3, 1'b1, 8'd128, -1, 0, 1'b0);

    // FIFO full on the 3rd and 4th attempts of a 10-sample burst.
    for (int e = 0; e < 64; e++) begin dat[e] = 8'($urandom); ful[e] = 1'b0; end
    ful[EARM + 2] = 1'b1; ful[EARM + 3] = 1'b1;
    run_capture("t3", 10, 1'b0, 8'd0, -1, 0, 1'b0);
    ful[EARM + 2] = 1'b0; ful[EARM + 3] = 1'b0;
    run_capture("t3b", 4, 1'b0, 8'd0, -1, 0, 1'b0);

    // Abort in the 3rd CAPTURE cycle with start/ack noise throughout.
    run_capture("t4", 20, 1'b0, 8'd0, EARM + 3, 1, 1'b1);

    run_capture("t5", 0, 1'b0, 8'd0, -1, 0, 1'b0);

    // Reset in DONE with overflow set.
    ful[EARM] = 1'b1;
    run_capture("t6", 2, 1'b0, 8'd0, -1, 2, 1'b0);

    for (int t = 0; t < 25; t++) begin
      int stp, knd;
      for (int e = 0; e < 64; e++) begin
        dat[e] = 8'($urandom);
        ful[e] = ($urandom_range(0, 3) == 0);
      end
      stp = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, EARM + 20)) : -1;
      knd = (stp > 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      run_capture($sformatf("rnd%0d", t), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                  8'($urandom), stp, knd, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
